// File: rtl/temp_filter_if.sv
// Sample/result bundle between the raw temperature source and temp_filter.
// The master drives samples; the slave (the filter) returns the conditioned value.
interface temp_filter_if #(
    parameter int W = 5
);
    logic         sample_valid;
    logic [W-1:0] sample;
    logic [W-1:0] temp_out;
    logic         filled;
    logic         rejected;

    modport master (
        output sample_valid,
        output sample,
        input  temp_out,
        input  filled,
        input  rejected
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output temp_out,
        output filled,
        output rejected
    );
endinterface

// File: rtl/temp_filter.sv
// Moving-average filter over a circular window of 2**LOG2_N raw temperature samples.
// Optional spike rejection while the window is full is enabled by defining SPIKE_REJECT_EN.
module temp_filter #(
    parameter int W         = 5,
    parameter int LOG2_N    = 2,
    parameter int SPIKE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    temp_filter_if.slave  bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = W + LOG2_N;
    localparam logic [LOG2_N:0] N_C = (LOG2_N + 1)'(N);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Configuration sanity: a window needs at least two entries and a non-negative limit.
    if (LOG2_N < 1 || SPIKE_LIM < 0) begin : g_bad_cfg
        $error("temp_filter: unsupported LOG2_N/SPIKE_LIM");
    end

    logic [W-1:0]      win_q [N];
    logic [W-1:0]      win_d [N];
    logic [LOG2_N-1:0] wptr_q, wptr_d;
    logic [LOG2_N:0]   cnt_q, cnt_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [W-1:0]      temp_out_q, temp_out_d;
    logic              filled_q, filled_d;
    logic              rejected_q, rejected_d;
    state_t            state_q, state_d;
    logic              accept_s;
    logic              reject_s;

`ifdef SPIKE_REJECT_EN
    localparam logic [W:0] LIM_C = (W + 1)'(SPIKE_LIM);

    logic [1:0] rej_cnt_q, rej_cnt_d;
    logic [W:0] diff_s;

    // Spike detection against the current output; two consecutive drops force the next sample in.
    always_comb begin
        diff_s   = {(W + 1){1'b0}};
        reject_s = 1'b0;
        if ({1'b0, bus.sample} >= {1'b0, temp_out_q}) begin
            diff_s = {1'b0, bus.sample} - {1'b0, temp_out_q};
        end else begin
            diff_s = {1'b0, temp_out_q} - {1'b0, bus.sample};
        end
        if (bus.sample_valid && (state_q == ST_RUN) && (diff_s > LIM_C)
            && (rej_cnt_q != 2'd2)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Consecutive-reject counter: cleared by any accepted sample.
    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (accept_s) begin
            rej_cnt_d = 2'd0;
        end else if (reject_s) begin
            rej_cnt_d = rej_cnt_q + 2'd1;
        end else begin
            rej_cnt_d = rej_cnt_q;
        end
    end

    // Reject counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_q <= 2'd0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
        end
    end
`else
    assign reject_s = 1'b0;
`endif

    assign accept_s = bus.sample_valid & ~reject_s;

    // Window update, running sum, fill tracking and output computation.
    always_comb begin
        win_d      = win_q;
        wptr_d     = wptr_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        temp_out_d = temp_out_q;
        filled_d   = filled_q;
        rejected_d = reject_s;
        if (accept_s) begin
            win_d[wptr_q] = bus.sample;
            // Oldest entry leaves as the new one enters, so the sum never exceeds N*(2**W-1).
            sum_d      = sum_q + SW'(bus.sample) - SW'(win_q[wptr_q]);
            wptr_d     = wptr_q + {{(LOG2_N - 1){1'b0}}, 1'b1};
            temp_out_d = W'(sum_d >> LOG2_N);
            case (state_q)
                ST_EMPTY, ST_FILL: begin
                    cnt_d = cnt_q + {{LOG2_N{1'b0}}, 1'b1};
                    if (cnt_d == N_C) begin
                        state_d  = ST_RUN;
                        filled_d = 1'b1;
                    end else begin
                        state_d  = ST_FILL;
                        filled_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    state_d  = ST_RUN;
                    filled_d = 1'b1;
                end
                default: begin
                    state_d  = ST_EMPTY;
                    filled_d = 1'b0;
                    cnt_d    = {(LOG2_N + 1){1'b0}};
                end
            endcase
        end else begin
            win_d      = win_q;
            sum_d      = sum_q;
            temp_out_d = temp_out_q;
        end
    end

    // State register: reset discards the whole window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= {W{1'b0}};
            end
            wptr_q     <= {LOG2_N{1'b0}};
            cnt_q      <= {(LOG2_N + 1){1'b0}};
            sum_q      <= {SW{1'b0}};
            temp_out_q <= {W{1'b0}};
            filled_q   <= 1'b0;
            rejected_q <= 1'b0;
            state_q    <= ST_EMPTY;
        end else begin
            win_q      <= win_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            temp_out_q <= temp_out_d;
            filled_q   <= filled_d;
            rejected_q <= rejected_d;
            state_q    <= state_d;
        end
    end

    assign bus.temp_out = temp_out_q;
    assign bus.filled   = filled_q;
    assign bus.rejected = rejected_q;
endmodule

// File: tb/tb_temp_filter.sv
// Self-checking bench for temp_filter: window-average model compared every cycle,
// plus hand-computed literal checkpoints for the directed scenarios.
module tb_temp_filter;
    localparam int W   = 5;
    localparam int L2N = 2;
    localparam int N   = 4;
    localparam int LIM = 4;
`ifdef SPIKE_REJECT_EN
    localparam bit SPIKE = 1'b1;
`else
    localparam bit SPIKE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    temp_filter_if #(.W(W)) bus ();
    temp_filter #(.W(W), .LOG2_N(L2N), .SPIKE_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: the last N accepted samples, an accepted-sample count and a reject streak.
    int m_win [N];
    int m_wp, m_cnt, m_rejc;
    int exp_temp, exp_filled, exp_rej;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_step(input bit r, input bit v, input int s);
        int sum;
        if (r) begin
            foreach (m_win[i]) m_win[i] = 0;
            m_wp = 0; m_cnt = 0; m_rejc = 0;
            exp_temp = 0; exp_filled = 0; exp_rej = 0;
        end else if (v) begin
            if (SPIKE && exp_filled == 1 && iabs(s - exp_temp) > LIM && m_rejc < 2) begin
                m_rejc++;
                exp_rej = 1;
            end else begin
                m_win[m_wp] = s;
                m_wp = (m_wp + 1) % N;
                if (m_cnt < N) m_cnt++;
                m_rejc = 0;
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                exp_temp   = sum / N;
                exp_filled = (m_cnt == N) ? 1 : 0;
                exp_rej    = 0;
            end
        end else begin
            exp_rej = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int s);
        @(negedge clk);
        rst = r;
        bus.sample_valid = v;
        bus.sample = s[W-1:0];
        @(posedge clk);
        #1;
        model_step(r, v, s);
    endtask

    task automatic lit(input string name, input int t, input int f, input int rj);
        check({name, "_temp"}, bus.temp_out, t);
        check({name, "_filled"}, bus.filled, f);
        check({name, "_rejected"}, bus.rejected, rj);
        check({name, "_model"}, exp_temp, t);
    endtask

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_temp", bus.temp_out, exp_temp);
            check("cyc_filled", bus.filled, exp_filled);
            check("cyc_rejected", bus.rejected, exp_rej);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cmp_en = 1'b1;
        lit("reset", 0, 0, 0);

        // Fill with 20s: filled only after the 4th.
        repeat (3) cycle(0, 1, 20);
        lit("fill3", 15, 0, 0);
        cycle(0, 1, 20);
        lit("fill4", 20, 1, 0);

        // Difference of exactly the limit is never a spike.
        cycle(0, 1, 24);
        lit("step24", 21, 1, 0);

        // Eight 10s: pointer wraps twice.
        repeat (4) cycle(0, 1, 10);
`ifndef SPIKE_REJECT_EN
        lit("tens4", 10, 1, 0);
`endif
        repeat (4) cycle(0, 1, 10);
`ifdef SPIKE_REJECT_EN
        lit("tens8", 16, 1, 1);
`else
        lit("tens8", 10, 1, 0);
`endif

        // Idle gaps of 0, 3 and 17 cycles between strobes.
        cycle(1, 0, 0);
        cycle(0, 1, 7);
        cycle(0, 1, 9);
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 7);
        lit("gap3", 5, 0, 0);
        repeat (17) cycle(0, 0, 0);
        cycle(0, 1, 9);
        lit("gap17", 8, 1, 0);

        // Reset mid-fill discards the window.
        cycle(1, 0, 0);
        cycle(0, 1, 12);
        cycle(0, 1, 12);
        cycle(1, 0, 0);
        lit("rst_mid", 0, 0, 0);
        repeat (3) cycle(0, 1, 12);
        lit("refill3", 9, 0, 0);
        cycle(0, 1, 12);
        lit("refill4", 12, 1, 0);

        // Reset wins over a simultaneous strobe.
        cycle(1, 1, 31);
        lit("rst_prio", 0, 0, 0);

        // Step from 20 to 30.
        repeat (4) cycle(0, 1, 20);
        cycle(0, 1, 30);
`ifdef SPIKE_REJECT_EN
        lit("spike1", 20, 1, 1);
        cycle(0, 1, 30);
        lit("spike2", 20, 1, 1);
        cycle(0, 1, 30);
        lit("spike3", 22, 1, 0);
`else
        lit("spike1", 22, 1, 0);
        cycle(0, 1, 30);
        lit("spike2", 25, 1, 0);
        cycle(0, 1, 30);
        lit("spike3", 27, 1, 0);
`endif

        // Mixed pattern: extremes, gaps and back-to-back strobes.
        for (int i = 0; i < 40; i++) begin
            cycle(0, (i % 3) != 0, (i * 13 + 5) % 32);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
